// File: rtl/rr_vn_p_arbiter_pkg.sv
// Shared definitions for the VN/VC round-robin output arbiter:
// index width helper, VN/VC index encoding and the FSM state encoding.
package rr_vn_p_arbiter_pkg;

  // Width of a binary index over n items. Never returns 0, so N==1 still gets a 1-bit pointer.
  function automatic int log2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int vn_vc_idx(input int vn, input int vc, input int num_vc);
    return vn * num_vc + vc;
  endfunction

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_vn_p_arbiter_if.sv
// Request/grant bundle between the input VC buffers (master) and the
// output-port arbiter (slave).
interface rr_vn_p_arbiter_if #(
  parameter int N      = 3,
  parameter int BITS_N = rr_vn_p_arbiter_pkg::log2(N)
);
  logic [N-1:0]      req_i;
  logic [N-1:0]      last_i;
  logic              ready_i;
  logic [N-1:0]      gnt_o;
  logic              gnt_valid_o;
  logic [BITS_N-1:0] gnt_idx_o;
  logic              err_o;

  modport master (
    output req_i, last_i, ready_i,
    input  gnt_o, gnt_valid_o, gnt_idx_o, err_o
  );

  modport slave (
    input  req_i, last_i, ready_i,
    output gnt_o, gnt_valid_o, gnt_idx_o, err_o
  );
endinterface

// File: rtl/rr_vn_p_rot.sv
// N-bit rotate right by amt; amt is always < N, so one conditional
// subtract gives the modulo even when N is not a power of two.
module rr_vn_p_rot #(
  parameter int N      = 3,
  parameter int BITS_N = 2
) (
  input  logic [N-1:0]      din,
  input  logic [BITS_N-1:0] amt,
  output logic [N-1:0]      dout
);

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    logic [BITS_N-1:0] src;

    always_comb begin
      int sel;
      sel = gi + int'(amt);
      if (sel >= N) sel = sel - N;
      src = BITS_N'(sel);
    end

    assign dout[gi] = din[src];
  end

endmodule

// File: rtl/rr_vn_p_arbiter.sv
// Round-robin output arbiter over NUM_VN*NUM_VC requesters; the grant is
// held for a whole packet and the pointer moves past the holder on release.
module rr_vn_p_arbiter
  import rr_vn_p_arbiter_pkg::*;
#(
  parameter int NUM_VC = 1,
  parameter int NUM_VN = 3
) (
  input  logic               clk,
  input  logic               rst_p,
  rr_vn_p_arbiter_if.slave   bus
);

  localparam int N      = NUM_VC * NUM_VN;
  localparam int BITS_N = log2(N);

  arb_state_t        state_reg, state_next;
  logic [BITS_N-1:0] ptr_reg, ptr_next;
  logic [BITS_N-1:0] holder_reg, holder_next;
  logic [N-1:0]      gnt_reg, gnt_next;
  logic              valid_reg, valid_next;
  logic              err_reg, err_next;

  logic [BITS_N-1:0] holder_inc;
  logic [BITS_N-1:0] arb_ptr;
  logic [N-1:0]      rr;
  logic [BITS_N-1:0] off;
  logic [BITS_N-1:0] win;
  logic              any_req;
  logic              rel;
  logic              do_grant;

  assign any_req    = |bus.req_i;
  assign holder_inc = (holder_reg == BITS_N'(N - 1)) ? '0 : holder_reg + 1'b1;
  // While locked, the only grant that can happen is a regrant after release,
  // which arbitrates from the slot just past the holder.
  assign arb_ptr    = (state_reg == ST_LOCKED) ? holder_inc : ptr_reg;

  rr_vn_p_rot #(.N(N), .BITS_N(BITS_N)) u_rot (
    .din  (bus.req_i),
    .amt  (arb_ptr),
    .dout (rr)
  );

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rr[i]) off = BITS_N'(i);
    end
  end

  always_comb begin
    int sum;
    sum = int'(arb_ptr) + int'(off);
    if (sum >= N) sum = sum - N;
    win = BITS_N'(sum);
  end

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    holder_next = holder_reg;
    gnt_next    = gnt_reg;
    valid_next  = valid_reg;
    err_next    = 1'b0;
    rel         = 1'b0;

    if (state_reg == ST_LOCKED) begin
      // Abort takes precedence and ignores ready_i.
      if (!bus.req_i[holder_reg]) begin
        err_next = 1'b1;
        rel      = 1'b1;
      end else if (valid_reg && bus.ready_i && bus.last_i[holder_reg]) begin
        rel = 1'b1;
      end
    end

    do_grant = any_req && (rel || (state_reg == ST_IDLE));

    if (rel) begin
      ptr_next    = holder_inc;
      state_next  = ST_IDLE;
      gnt_next    = '0;
      valid_next  = 1'b0;
      holder_next = '0;
    end

    if (do_grant) begin
      gnt_next      = '0;
      gnt_next[win] = 1'b1;
      holder_next   = win;
      valid_next    = 1'b1;
      state_next    = ST_LOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= '0;
      holder_reg <= '0;
      gnt_reg    <= '0;
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      holder_reg <= holder_next;
      gnt_reg    <= gnt_next;
      valid_reg  <= valid_next;
      err_reg    <= err_next;
    end
  end

  assign bus.gnt_o       = gnt_reg;
  assign bus.gnt_valid_o = valid_reg;
  assign bus.gnt_idx_o   = holder_reg;
  assign bus.err_o       = err_reg;

endmodule

// File: tb/tb_rr_vn_p_arbiter.sv
// Self-checking bench for rr_vn_p_arbiter (NUM_VC=1, NUM_VN=3): expected
// {gnt, valid, idx, err} words are queued as stimulus is driven and popped after each edge.
module tb_rr_vn_p_arbiter;

  logic clk;
  logic rst_p;
  int   checks;
  int   passes;

  logic [6:0] sb[$];

  rr_vn_p_arbiter_if #(.N(3), .BITS_N(2)) bus ();

  rr_vn_p_arbiter #(.NUM_VC(1), .NUM_VN(3)) dut (
    .clk   (clk),
    .rst_p (rst_p),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word: idx < 0 means no grant.
  function automatic logic [6:0] g(input int idx, input bit err);
    logic [2:0] oh;
    if (idx < 0) return {6'b000000, err};
    oh = 3'b001 << idx;
    return {oh, 1'b1, 2'(idx), err};
  endfunction

  task automatic drive(input logic [2:0] rq, input logic [2:0] lt, input logic rdy,
                       input logic [6:0] expv);
    bus.req_i   = rq;
    bus.last_i  = lt;
    bus.ready_i = rdy;
    sb.push_back(expv);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_p       = 1'b1;
    bus.req_i   = '0;
    bus.last_i  = '0;
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    rst_p = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    rst_p = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(3'b111, 3'b111, 1'b1, 7'b0000000);
      got = {bus.gnt_o, bus.gnt_valid_o, bus.gnt_idx_o, bus.err_o};
      checks++;
      if (got !== sb.pop_front()) $display("FAIL reset cycle %0d: got %b want 0000000", i, got);
      else passes++;
    end
    rst_p = 1'b0;
  endtask

  task automatic test_round_robin();
    int ix[6] = '{0, 1, 2, 0, 1, 2};
    logic [6:0] got, expv, mask;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(3'b111, 3'b111, 1'b1, g(ix[i], 1'b0));
      got  = {bus.gnt_o, bus.gnt_valid_o, bus.gnt_idx_o, bus.err_o};
      expv = sb.pop_front();
      mask = expv[3] ? 7'h7f : 7'h79;
      checks++;
      if ((got & mask) !== (expv & mask)) $display("FAIL round_robin step %0d: got %b want %b", i, got, expv);
      else passes++;
    end
  endtask

  task automatic test_multi_flit();
    logic [2:0] lt[5] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010};
    int ix[5] = '{0, 0, 0, 1, 0};
    logic [6:0] got, expv, mask;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(3'b011, lt[i], 1'b1, g(ix[i], 1'b0));
      got  = {bus.gnt_o, bus.gnt_valid_o, bus.gnt_idx_o, bus.err_o};
      expv = sb.pop_front();
      mask = expv[3] ? 7'h7f : 7'h79;
      checks++;
      if ((got & mask) !== (expv & mask)) $display("FAIL multi_flit step %0d: got %b want %b", i, got, expv);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] lt[8] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b001, 3'b010};
    logic       rd[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int ix[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    logic [6:0] got, expv, mask;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(3'b011, lt[i], rd[i], g(ix[i], 1'b0));
      got  = {bus.gnt_o, bus.gnt_valid_o, bus.gnt_idx_o, bus.err_o};
      expv = sb.pop_front();
      mask = expv[3] ? 7'h7f : 7'h79;
      checks++;
      if ((got & mask) !== (expv & mask)) $display("FAIL backpressure step %0d: got %b want %b", i, got, expv);
      else passes++;
    end
  endtask

  task automatic test_wrap();
    logic [2:0] rq[4] = '{3'b010, 3'b111, 3'b101, 3'b101};
    logic [2:0] lt[4] = '{3'b000, 3'b010, 3'b100, 3'b001};
    int ix[4] = '{1, 2, 0, 2};
    logic [6:0] got, expv, mask;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(rq[i], lt[i], 1'b1, g(ix[i], 1'b0));
      got  = {bus.gnt_o, bus.gnt_valid_o, bus.gnt_idx_o, bus.err_o};
      expv = sb.pop_front();
      mask = expv[3] ? 7'h7f : 7'h79;
      checks++;
      if ((got & mask) !== (expv & mask)) $display("FAIL wrap step %0d: got %b want %b", i, got, expv);
      else passes++;
    end
  endtask

  task automatic test_abort();
    logic [2:0] rq[6] = '{3'b010, 3'b101, 3'b101, 3'b001, 3'b000, 3'b000};
    logic       rd[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int ix[6] = '{1, 2, 2, 0, -1, -1};
    bit er[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [6:0] got, expv, mask;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(rq[i], 3'b000, rd[i], g(ix[i], er[i]));
      got  = {bus.gnt_o, bus.gnt_valid_o, bus.gnt_idx_o, bus.err_o};
      expv = sb.pop_front();
      mask = expv[3] ? 7'h7f : 7'h79;
      checks++;
      if ((got & mask) !== (expv & mask)) $display("FAIL abort step %0d: got %b want %b", i, got, expv);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [6:0] got, expv, mask;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      drive(3'b111, 3'b000, 1'b1, g(0, 1'b0));
      got  = {bus.gnt_o, bus.gnt_valid_o, bus.gnt_idx_o, bus.err_o};
      expv = sb.pop_front();
      mask = expv[3] ? 7'h7f : 7'h79;
      checks++;
      if ((got & mask) !== (expv & mask)) $display("FAIL mid_reset lock %0d: got %b want %b", i, got, expv);
      else passes++;
    end
    rst_p = 1'b1;
    drive(3'b111, 3'b000, 1'b1, 7'b0000000);
    rst_p = 1'b0;
    got  = {bus.gnt_o, bus.gnt_valid_o, bus.gnt_idx_o, bus.err_o};
    expv = sb.pop_front();
    checks++;
    if (got !== expv) $display("FAIL mid_reset clear: got %b want %b", got, expv);
    else passes++;
    drive(3'b110, 3'b000, 1'b1, g(1, 1'b0));
    got  = {bus.gnt_o, bus.gnt_valid_o, bus.gnt_idx_o, bus.err_o};
    expv = sb.pop_front();
    checks++;
    if (got !== expv) $display("FAIL mid_reset regrant: got %b want %b", got, expv);
    else passes++;
  endtask

  initial begin
    checks      = 0;
    passes      = 0;
    rst_p       = 1'b1;
    bus.req_i   = '0;
    bus.last_i  = '0;
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_multi_flit();
    test_backpressure();
    test_wrap();
    test_abort();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
